// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, opcode and control-field encodings for the multicycle MIPS core
package multicycle_pkg;

    localparam int OPW     = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_t;
    typedef enum logic [1:0] {SRCB_REGB = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} srcb_t;
    typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pcsrc_t;

    typedef struct packed {
        logic   pc_write;
        logic   pc_write_cond;
        logic   iord;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   reg_write;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        pcsrc_t pc_source;
        logic   instr_done;
        logic   illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller/datapath bundle; mem_ready exists only with MULTICYCLE_MEM_WAIT_EN
interface multicycle_ctrl_if;
    import multicycle_pkg::*;

    logic [OPW-1:0] Op;
    logic           Zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic           mem_ready;
`endif
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic instr_done, illegal_op;

    modport master (
        input  Op, Zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
        input  mem_ready,
`endif
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output instr_done, illegal_op
    );

    modport slave (
        output Op, Zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
        output mem_ready,
`endif
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  instr_done, illegal_op
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational state -> control word; MULTICYCLE_MEM_WAIT_EN adds mem_ready gating
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_t         state_i,
    input  logic [OPW-1:0] op_i,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic           mem_ready_i,
`endif
    output ctrl_t          ctrl_o
);

    logic mem_ok;
`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = mem_ready_i;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                // PC/IR only advance on the cycle the fetch actually completes
                ctrl_o.pc_write  = mem_ok;
                ctrl_o.ir_write  = mem_ok;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = !(op_i inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ok;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REGB;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM; MULTICYCLE_MEM_WAIT_EN stalls memory states on mem_ready
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   mem_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            // Final states and any unreachable encoding fall back to FETCH
            default:   state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (bus.Op),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready_i (bus.mem_ready),
`endif
        .ctrl_o      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a per-instruction step model
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic done, ill;
    } ctl_t;

    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5;
    localparam int PH_EX = 6, PH_RWB = 7, PH_BR = 8, PH_J = 9, PH_AE = 10, PH_AW = 11;

    int seq[$];
    ctl_t obs, exp_c;

    function automatic logic supported(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Expected datapath controls for each step of an instruction, straight from the step table
    function automatic ctl_t phase_ctl(input int ph, input logic ill);
        ctl_t c = '0;
        case (ph)
            PH_F:   begin c.pcw = 1; c.mr = 1; c.irw = 1; c.asb = 2'b01; end
            PH_D:   begin c.asb = 2'b11; c.ill = ill; end
            PH_MA:  begin c.asa = 1; c.asb = 2'b10; end
            PH_MR:  begin c.mr = 1; c.iord = 1; end
            PH_MWB: begin c.rw = 1; c.m2r = 1; c.done = 1; end
            PH_MW:  begin c.mw = 1; c.iord = 1; c.done = 1; end
            PH_EX:  begin c.asa = 1; c.aop = 2'b10; end
            PH_RWB: begin c.rw = 1; c.rdst = 1; c.done = 1; end
            PH_BR:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; end
            PH_J:   begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
            PH_AE:  begin c.asa = 1; c.asb = 2'b10; end
            PH_AW:  begin c.rw = 1; c.done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic void build_seq(input logic [5:0] op);
        seq.delete();
        seq.push_back(PH_F);
        seq.push_back(PH_D);
        case (op)
            6'b100011: begin seq.push_back(PH_MA); seq.push_back(PH_MR); seq.push_back(PH_MWB); end
            6'b101011: begin seq.push_back(PH_MA); seq.push_back(PH_MW); end
            6'b000000: begin seq.push_back(PH_EX); seq.push_back(PH_RWB); end
            6'b000100: seq.push_back(PH_BR);
            6'b000010: seq.push_back(PH_J);
            6'b001000: begin seq.push_back(PH_AE); seq.push_back(PH_AW); end
            default: ;
        endcase
    endfunction

    function automatic ctl_t sample();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.instr_done, bus.illegal_op};
    endfunction

    // Entered at a falling edge while in FETCH; leaves at the falling edge of the next FETCH
    task automatic run_instr(input logic [5:0] op, input string tag);
        int cyc = 0;
        int done_at = -1;
        bus.Op = op;
        build_seq(op);
        foreach (seq[k]) begin
            bus.Zero = 1'($urandom);
            #1;
            obs   = sample();
            exp_c = phase_ctl(seq[k], !supported(op));
            n_checks++;
            if (obs !== exp_c) begin
                n_fail++;
                $display("FAIL %s op=%b step %0d: got %h, expected %h", tag, op, k, obs, exp_c);
            end
            cyc++;
            if (obs.done && done_at < 0) done_at = cyc;
            @(negedge clk);
        end
        if (supported(op)) begin
            n_checks++;
            if (done_at != seq.size()) begin
                n_fail++;
                $display("FAIL %s_done_cycle op=%b: got %0d, expected %0d", tag, op, done_at, seq.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Op = 6'b100011;
        bus.Zero = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (2) @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, expected 0", obs); end
        rst_n = 1'b1;
        #1;
        obs = sample();
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL idle_after_release: got %h, expected 0", obs); end
        @(negedge clk);
        obs = sample();
        exp_c = phase_ctl(PH_F, 1'b0);
        n_checks++;
        if (obs !== exp_c) begin n_fail++; $display("FAIL first_fetch: got %h, expected %h", obs, exp_c); end
    endtask

    task automatic test_rtype();          run_instr(6'b000000, "rtype");   endtask
    task automatic test_lw_sw();          run_instr(6'b100011, "lw"); run_instr(6'b101011, "sw"); endtask
    task automatic test_branch_jump();    run_instr(6'b000100, "beq"); run_instr(6'b000010, "j"); endtask
    task automatic test_illegal();        run_instr(6'b111111, "illegal"); run_instr(6'b001000, "addi"); endtask

    task automatic test_back_to_back();
        logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 6);
            logic [5:0] op = (sel == 6) ? 6'($urandom) : ops[sel];
            run_instr(op, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        bus.Op = 6'b101011;
        repeat (3) @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== phase_ctl(PH_MW, 1'b0)) begin
            n_fail++; $display("FAIL mid_memwr: got %h, expected %h", obs, phase_ctl(PH_MW, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1 obs = sample();
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL async_reset_drop: got %h, expected 0", obs); end
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL held_reset: got %h, expected 0", obs); end
        rst_n = 1'b1;
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== phase_ctl(PH_F, 1'b0)) begin
            n_fail++; $display("FAIL restart_fetch: got %h, expected %h", obs, phase_ctl(PH_F, 1'b0));
        end
        run_instr(6'b100011, "after_reset");
    endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
    task automatic test_mem_wait();
        int pcw_cnt = 0;
        bus.Op = 6'b101011;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1 obs = sample();
            pcw_cnt += int'(obs.pcw);
            n_checks++;
            if (obs.pcw !== (i == 3) || obs.irw !== (i == 3) || obs.mr !== 1'b1) begin
                n_fail++; $display("FAIL fetch_wait cyc %0d: got %h", i, obs);
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 obs = sample();
        n_checks++;
        if (obs.mw !== 1'b1 || obs.iord !== 1'b1 || obs.done !== 1'b0) begin
            n_fail++; $display("FAIL memwr_wait: got %h", obs);
        end
        rst_n = 1'b0;
        #1 obs = sample();
        n_checks++;
        if (obs !== '0 || pcw_cnt != 1) begin
            n_fail++; $display("FAIL memwr_reset: got %h pcw_cnt %0d, expected 0 and 1", obs, pcw_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef MULTICYCLE_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
